// File: rtl/alu_shifter.sv
// Purpose : 16-bit shifter (SLL / SRA / ROR / pass) built as a 4-stage log barrel, with zero/sign/overflow flags.
// Latency : 1 cycle, registered outputs; a new operation is accepted on every clk edge.
// Backpress: none; the block is free-running and has no stall input.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   a      - 16-bit signed operand
//   b      - 4-bit shift amount (0..15)
//   mode   - 00 SLL, 01 SRA, 10 ROR, 11 pass-through
//   result - registered shift result
//   zero   - registered flag: result == 0
//   sign   - registered flag: result[15]
//   ovfl   - registered flag: signed overflow on SLL
//
// Build option: define ALU_SHIFTER_FLAGS_EN to compute the flags; otherwise
// zero/sign/ovfl are tied to 0 and only result is produced.

module alu_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [3:0]  b,
    input  logic [1:0]  mode,
    output logic [15:0] result,
    output logic        zero,
    output logic        sign,
    output logic        ovfl
);

    localparam logic [1:0] MODE_SLL  = 2'b00;
    localparam logic [1:0] MODE_SRA  = 2'b01;
    localparam logic [1:0] MODE_ROR  = 2'b10;

    // Three parallel barrel chains, one per shift flavour; each stage is
    // controlled by one bit of b (1, 2, 4, 8).
    logic [15:0] sll_s0, sll_s1, sll_s2, sll_s3;
    logic [15:0] sra_s0, sra_s1, sra_s2, sra_s3;
    logic [15:0] ror_s0, ror_s1, ror_s2, ror_s3;
    logic [15:0] shift_dat;

    always_comb begin
        sll_s0 = b[0] ? {a[14:0],      1'b0}  : a;
        sll_s1 = b[1] ? {sll_s0[13:0], 2'b0}  : sll_s0;
        sll_s2 = b[2] ? {sll_s1[11:0], 4'b0}  : sll_s1;
        sll_s3 = b[3] ? {sll_s2[7:0],  8'b0}  : sll_s2;

        // Vacated upper bits take the operand sign; since every stage
        // preserves bit 15, each stage can replicate its own input's MSB.
        sra_s0 = b[0] ? {{1{a[15]}},      a[15:1]}      : a;
        sra_s1 = b[1] ? {{2{sra_s0[15]}}, sra_s0[15:2]} : sra_s0;
        sra_s2 = b[2] ? {{4{sra_s1[15]}}, sra_s1[15:4]} : sra_s1;
        sra_s3 = b[3] ? {{8{sra_s2[15]}}, sra_s2[15:8]} : sra_s2;

        ror_s0 = b[0] ? {a[0],        a[15:1]}      : a;
        ror_s1 = b[1] ? {ror_s0[1:0], ror_s0[15:2]} : ror_s0;
        ror_s2 = b[2] ? {ror_s1[3:0], ror_s1[15:4]} : ror_s1;
        ror_s3 = b[3] ? {ror_s2[7:0], ror_s2[15:8]} : ror_s2;

        case (mode)
            MODE_SLL: shift_dat = sll_s3;
            MODE_SRA: shift_dat = sra_s3;
            MODE_ROR: shift_dat = ror_s3;
            default:  shift_dat = a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result <= 16'h0000;
        end else begin
            result <= shift_dat;
        end
    end

`ifdef ALU_SHIFTER_FLAGS_EN
    // SLL overflows when any of a[15-1 .. 15-b] differs from a[15]: those
    // bits are either lost or land in the sign position, so the shifted
    // value no longer represents a * 2^b.
    logic ovfl_c;

    always_comb begin
        ovfl_c = 1'b0;
        if (mode == MODE_SLL) begin
            for (int i = 1; i < 16; i++) begin
                if ((4'(i) <= b) && (a[15-i] != a[15])) begin
                    ovfl_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero <= 1'b1;
            sign <= 1'b0;
            ovfl <= 1'b0;
        end else begin
            zero <= (shift_dat == 16'h0000);
            sign <= shift_dat[15];
            ovfl <= ovfl_c;
        end
    end
`else
    assign zero = 1'b0;
    assign sign = 1'b0;
    assign ovfl = 1'b0;
`endif

endmodule

// File: tb/tb_alu_shifter.sv
// Purpose : randomized + directed bench for alu_shifter with a queue scoreboard.
// Latency : expects each sampled operation one clk edge after it is driven.
// Backpress: none; one expectation is queued per driven edge.

module tb_alu_shifter;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [3:0]  b;
    logic [1:0]  mode;
    logic [15:0] result;
    logic        zero;
    logic        sign;
    logic        ovfl;

    alu_shifter dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .b      (b),
        .mode   (mode),
        .result (result),
        .zero   (zero),
        .sign   (sign),
        .ovfl   (ovfl)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        s;
        logic        o;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors    = 0;
    int   miscompares = 0;

    // Flags only exist in the flagged build; otherwise they must read 0.
    function automatic exp_t mk(logic [15:0] res, logic z, logic s, logic o);
        exp_t e;
        e.res = res;
`ifdef ALU_SHIFTER_FLAGS_EN
        e.z = z;
        e.s = s;
        e.o = o;
`else
        e.z = 1'b0;
        e.s = 1'b0;
        e.o = 1'b0;
`endif
        return e;
    endfunction

    // Reference model: plain arithmetic on the operand values.
    function automatic exp_t model(logic [15:0] av, logic [3:0] bv, logic [1:0] mv);
        logic [31:0] w;
        logic [15:0] r;
        int          full;
        logic        o;
        case (mv)
            2'b00: begin
                w = {16'h0000, av} << bv;
                r = w[15:0];
            end
            2'b01: r = 16'($signed(av) >>> bv);
            2'b10: begin
                w = {av, av} >> bv;
                r = w[15:0];
            end
            default: r = av;
        endcase
        // Overflow: true product a*2^b does not fit a signed 16-bit value.
        full = int'($signed(av)) * (1 << bv);
        o = (mv == 2'b00) && ((full > 32767) || (full < -32768));
        return mk(r, r == 16'h0000, r[15], o);
    endfunction

    task automatic drive(input logic r, input logic [15:0] av, input logic [3:0] bv,
                         input logic [1:0] mv, input exp_t e);
        @(negedge clk);
        rst_n = r;
        a     = av;
        b     = bv;
        mode  = mv;
        sb_q.push_back(e);
    endtask

    task automatic op(input logic [15:0] av, input logic [3:0] bv, input logic [1:0] mv);
        drive(1'b1, av, bv, mv, model(av, bv, mv));
    endtask

    task automatic rst_cycle(input logic [15:0] av, input logic [3:0] bv, input logic [1:0] mv);
        drive(1'b0, av, bv, mv, mk(16'h0000, 1'b1, 1'b0, 1'b0));
    endtask

    // Monitor: compares the registered outputs just after each edge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            vectors++;
            if (result !== mon_e.res || zero !== mon_e.z || sign !== mon_e.s || ovfl !== mon_e.o) begin
                miscompares++;
                $display("FAIL vec%0d: got result=%h zero=%b sign=%b ovfl=%b, want result=%h zero=%b sign=%b ovfl=%b",
                         vectors, result, zero, sign, ovfl, mon_e.res, mon_e.z, mon_e.s, mon_e.o);
            end
        end
    end

    initial begin
        logic [15:0] aa;
        rst_n = 1'b0;
        a     = 16'h0;
        b     = 4'h0;
        mode  = 2'b00;

        // Reset state, with non-zero inputs present to show reset wins.
        rst_cycle(16'hFFFF, 4'd3, 2'b00);
        rst_cycle(16'h8001, 4'd1, 2'b10);

        // Directed values with literal expectations.
        drive(1'b1, 16'h1234, 4'd3,  2'b00, mk(16'h91A0, 1'b0, 1'b1, 1'b1));
        drive(1'b1, 16'hEDCC, 4'd3,  2'b01, mk(16'hFDB9, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 16'hF000, 4'd4,  2'b10, mk(16'h0F00, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 16'h0001, 4'd1,  2'b10, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 16'h8000, 4'd1,  2'b00, mk(16'h0000, 1'b1, 1'b0, 1'b1));
        for (int m = 0; m < 4; m++)
            drive(1'b1, 16'h1234, 4'd0, 2'(m), mk(16'h1234, 1'b0, 1'b0, 1'b0));
        // b = 15 boundaries.
        drive(1'b1, 16'h0001, 4'd15, 2'b00, mk(16'h8000, 1'b0, 1'b1, 1'b1));
        drive(1'b1, 16'hFFFF, 4'd15, 2'b00, mk(16'h8000, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 16'h8000, 4'd15, 2'b01, mk(16'hFFFF, 1'b0, 1'b1, 1'b0));
        drive(1'b1, 16'h4000, 4'd15, 2'b01, mk(16'h0000, 1'b1, 1'b0, 1'b0));
        drive(1'b1, 16'h8001, 4'd15, 2'b10, mk(16'h0003, 1'b0, 1'b0, 1'b0));
        drive(1'b1, 16'hABCD, 4'd9,  2'b11, mk(16'hABCD, 1'b0, 1'b1, 1'b0));

        // Reset in the middle of a stream, then an immediate new result.
        for (int k = 0; k < 4; k++)
            op(16'($urandom), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
        rst_cycle(16'h7FFF, 4'd1, 2'b00);
        drive(1'b1, 16'h1234, 4'd3, 2'b00, mk(16'h91A0, 1'b0, 1'b1, 1'b1));
        op(16'h00F0, 4'd2, 2'b01);

        // Random operands, every shift amount and every mode.
        for (int k = 0; k < 1000; k++) begin
            aa = 16'($urandom);
            for (int bb = 0; bb < 16; bb++)
                for (int mm = 0; mm < 4; mm++)
                    op(aa, 4'(bb), 2'(mm));
        end

        // Drain the scoreboard within a bounded number of edges.
        for (int w = 0; w < 5 && sb_q.size() > 0; w++)
            @(posedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
